// File: rtl/alu_issue_wb.sv
// Decode/issue + writeback stage around a combinational 16-bit ALU.
// One instruction is in flight at a time: IDLE accepts, EXEC drives the ALU,
// WB commits the captured result to the 8-entry register file.
module alu_issue_wb #(
  parameter int DATA_WIDTH   = 16,
  parameter bit IMM_SIGN_EXT = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [15:0]           instr,
  output logic [DATA_WIDTH-1:0] alu_operand1,
  output logic [DATA_WIDTH-1:0] alu_operand2,
  output logic [2:0]            alu_operation,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  wb_valid,
  output logic [2:0]            wb_addr,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  illegal,
  output logic                  busy,
  input  logic [2:0]            dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  // Instruction word layout; `low` is either {rs2, unused} or imm6.
  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic       imm;
    logic [5:0] low;
  } instr_t;

  localparam logic [2:0] OP_SHL = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  state_t                state, state_nxt;
  instr_t                dec;
  logic                  accept;
  logic                  legal;
  logic [2:0]            rs2;
  logic [DATA_WIDTH-1:0] rs1_val, rs2_val, imm_ext, opnd2_nxt;
  logic [DATA_WIDTH-1:0] result_q;
  logic [2:0]            rd_q;
  logic [DATA_WIDTH-1:0] rf [8];

  assign dec    = instr_t'(instr);
  assign rs2    = dec.low[5:3];
  assign accept = instr_valid & instr_ready;

  // Reserved opcodes 001/010/011 are rejected at issue.
  always_comb begin
    legal = 1'b0;
    case (dec.op)
      OP_SHL, OP_ADD, OP_AND, OP_OR, OP_NOT: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
  end

  // Register-file reads happen in the accept cycle; r0 is hard-wired to 0.
  always_comb begin
    rs1_val = (dec.rs1 == 3'd0) ? '0 : rf[dec.rs1];
    rs2_val = (rs2 == 3'd0)     ? '0 : rf[rs2];
  end

  // imm6 extension; the replicated bit is 0 when zero-extending.
  assign imm_ext = {{(DATA_WIDTH-6){IMM_SIGN_EXT & dec.low[5]}}, dec.low};

  // Second operand select: NOT ignores operand2 and gets a clean 0.
  always_comb begin
    opnd2_nxt = rs2_val;
    if (dec.op == OP_NOT) opnd2_nxt = '0;
    else if (dec.imm)     opnd2_nxt = imm_ext;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and handshake/status outputs.
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    busy        = 1'b0;
    wb_valid    = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid && legal) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        busy      = 1'b1;
        state_nxt = S_WB;
      end
      S_WB: begin
        busy      = 1'b1;
        wb_valid  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Issue registers feed the ALU directly; they only load on a legal accept,
  // so the ALU inputs hold their last values outside EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_operation <= '0;
      alu_operand1  <= '0;
      alu_operand2  <= '0;
      rd_q          <= '0;
    end else if (accept && legal) begin
      alu_operation <= dec.op;
      alu_operand1  <= rs1_val;
      alu_operand2  <= opnd2_nxt;
      rd_q          <= dec.rd;
    end
  end

  // Capture the combinational ALU result at the end of EXEC.
  always_ff @(posedge clk) begin
    if (reset)                result_q <= '0;
    else if (state == S_EXEC) result_q <= alu_result;
  end

  // One-cycle illegal pulse following acceptance of a reserved opcode.
  always_ff @(posedge clk) begin
    if (reset) illegal <= 1'b0;
    else       illegal <= accept & ~legal;
  end

  // Register-file write in WB; r0 writes are dropped (wb_valid still pulses).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (state == S_WB && rd_q != 3'd0) begin
      rf[rd_q] <= result_q;
    end
  end

  assign wb_addr  = rd_q;
  assign wb_data  = result_q;
  assign dbg_data = (dbg_addr == 3'd0) ? '0 : rf[dbg_addr];

endmodule
